conv_seq_engine: RTL

- Parametrised convolution sequencer; next generation of the NPU's fixed single-channel conv loop.
- Adds multi-channel accumulation, power-of-two stride, stall handshake, abort and configuration error reporting.
- Generates image-SRAM and weight-SRAM read addresses plus MAC control tags, delay-aligned to SRAM read latency.
- Sits between the top-level control FSM and sram_controller/convolution MAC.

---
 rtl/conv_seq_engine.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_seq_engine.sv
// Convolution read sequencer: walks r/c/ch/kr/kc, issues image and weight SRAM
// reads, and delays the MAC control tags by the SRAM read latency.
module conv_seq_engine #(
    parameter int unsigned ADDR_WIDTH         = 13,
    parameter int unsigned MAX_CHANNELS       = 64,
    parameter int unsigned NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
    parameter int unsigned READ_LATENCY       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         img_row,
    input  logic [ADDR_WIDTH-1:0]         img_col,
    input  logic [ADDR_WIDTH-1:0]         ker_row,
    input  logic [ADDR_WIDTH-1:0]         ker_col,
    input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
    input  logic [1:0]                    stride_log2,
    input  logic                          issue_ready,
    output logic [ADDR_WIDTH-1:0]         img_addr,
    output logic [ADDR_WIDTH-1:0]         ker_addr,
    output logic                          rd_en,
    output logic                          mac_valid,
    output logic                          mac_first,
    output logic                          mac_last,
    output logic [ADDR_WIDTH-1:0]         out_idx,
    output logic [ADDR_WIDTH-1:0]         out_row,
    output logic [ADDR_WIDTH-1:0]         out_col,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);
    localparam int unsigned AW  = ADDR_WIDTH;
    localparam int unsigned CW  = NUM_CHANNELS_WIDTH;
    localparam int unsigned LAT = READ_LATENCY;
    localparam int unsigned DW  = 3;

    typedef enum logic [1:0] {IDLE, CONFIG, RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [AW-1:0] cfg_img_row, cfg_img_col, cfg_ker_row, cfg_ker_col;
    logic [CW-1:0] cfg_nch;
    logic [1:0]    cfg_stride;
    logic          cfg_bad;
    logic [AW-1:0] img_plane, ker_plane;
    logic [AW-1:0] r, c, kr, kc, idx;
    logic [CW-1:0] ch;
    logic [DW-1:0] drain_cnt;

    logic          illegal_in, issue, flush, done_d, cfg_err_d, load_cfg;
    logic          kc_last, kr_last, ch_last, c_last, r_last;
    logic          sum_first, sum_last, at_end;
    logic [AW-1:0] r_n, c_n, kr_n, kc_n;
    logic [CW-1:0] ch_n;
    logic [AW-1:0] img_addr_n, ker_addr_n;

    logic          pv   [LAT];
    logic          pf   [LAT];
    logic          pl   [LAT];
    logic [AW-1:0] pidx [LAT];

    assign illegal_in = (img_row == '0) || (img_col == '0) || (ker_row == '0) ||
                        (ker_col == '0) || (num_channels == '0) ||
                        (num_channels > CW'(MAX_CHANNELS)) ||
                        (ker_row > img_row) || (ker_col > img_col);

    // Loop-nest position after the current issue and the addresses it maps to.
    always_comb begin
        kc_last   = (kc == cfg_ker_col - AW'(1));
        kr_last   = (kr == cfg_ker_row - AW'(1));
        ch_last   = (ch == cfg_nch - CW'(1));
        c_last    = (c == out_col - AW'(1));
        r_last    = (r == out_row - AW'(1));
        sum_first = (ch == '0) && (kr == '0) && (kc == '0);
        sum_last  = ch_last && kr_last && kc_last;
        at_end    = sum_last && c_last && r_last;
        r_n  = r;
        c_n  = c;
        ch_n = ch;
        kr_n = kr;
        kc_n = kc + AW'(1);
        if (kc_last) begin
            kc_n = '0;
            kr_n = kr + AW'(1);
            if (kr_last) begin
                kr_n = '0;
                ch_n = ch + CW'(1);
                if (ch_last) begin
                    ch_n = '0;
                    c_n  = c + AW'(1);
                    if (c_last) begin
                        c_n = '0;
                        r_n = r + AW'(1);
                    end
                end
            end
        end
        img_addr_n = AW'(ch_n) * img_plane + ((r_n << cfg_stride) + kr_n) * cfg_img_col
                   + (c_n << cfg_stride) + kc_n;
        ker_addr_n = AW'(ch_n) * ker_plane + kr_n * cfg_ker_col + kc_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Abort takes priority over any issue, including the final one.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        flush      = 1'b0;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        load_cfg   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CONFIG;
                    load_cfg   = 1'b1;
                    cfg_err_d  = illegal_in;
                end
            end
            CONFIG: begin
                if (abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else begin
                    state_next = cfg_bad ? IDLE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else if (issue_ready) begin
                    issue = 1'b1;
                    if (at_end) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end else if (drain_cnt == DW'(LAT - 1)) begin
                    state_next = IDLE;
                    done_d     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_en = issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_img_row <= '0;
            cfg_img_col <= '0;
            cfg_ker_row <= '0;
            cfg_ker_col <= '0;
            cfg_nch     <= '0;
            cfg_stride  <= '0;
            cfg_bad     <= 1'b0;
            img_plane   <= '0;
            ker_plane   <= '0;
            r           <= '0;
            c           <= '0;
            ch          <= '0;
            kr          <= '0;
            kc          <= '0;
            idx         <= '0;
            img_addr    <= '0;
            ker_addr    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            done      <= done_d;
            cfg_err   <= cfg_err_d;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            if (load_cfg) begin
                cfg_img_row <= img_row;
                cfg_img_col <= img_col;
                cfg_ker_row <= ker_row;
                cfg_ker_col <= ker_col;
                cfg_nch     <= num_channels;
                cfg_stride  <= stride_log2;
                cfg_bad     <= illegal_in;
            end
            if (state == CONFIG) begin
                out_row   <= cfg_bad ? '0 : ((cfg_img_row - cfg_ker_row) >> cfg_stride) + AW'(1);
                out_col   <= cfg_bad ? '0 : ((cfg_img_col - cfg_ker_col) >> cfg_stride) + AW'(1);
                img_plane <= cfg_img_row * cfg_img_col;
                ker_plane <= cfg_ker_row * cfg_ker_col;
                r         <= '0;
                c         <= '0;
                ch        <= '0;
                kr        <= '0;
                kc        <= '0;
                idx       <= '0;
                img_addr  <= '0;
                ker_addr  <= '0;
            end else if (issue) begin
                r        <= r_n;
                c        <= c_n;
                ch       <= ch_n;
                kr       <= kr_n;
                kc       <= kc_n;
                idx      <= sum_last ? idx + AW'(1) : idx;
                img_addr <= img_addr_n;
                ker_addr <= ker_addr_n;
            end
        end
    end

    // Tag delay line; advances every cycle so tags stay aligned with SRAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pv[i]   <= 1'b0;
                pf[i]   <= 1'b0;
                pl[i]   <= 1'b0;
                pidx[i] <= '0;
            end
        end else begin
            pv[0]   <= issue;
            pf[0]   <= sum_first;
            pl[0]   <= sum_last;
            pidx[0] <= idx;
            for (int i = 1; i < int'(LAT); i++) begin
                pv[i]   <= pv[i-1];
                pf[i]   <= pf[i-1];
                pl[i]   <= pl[i-1];
                pidx[i] <= pidx[i-1];
            end
            if (flush) begin
                for (int i = 0; i < int'(LAT); i++) pv[i] <= 1'b0;
            end
        end
    end

    assign mac_valid = pv[LAT-1];
    assign mac_first = pv[LAT-1] & pf[LAT-1];
    assign mac_last  = pv[LAT-1] & pl[LAT-1];
    assign out_idx   = pidx[LAT-1];

endmodule
